// File: rtl/exalu_pkg.sv
// rtl/exalu_pkg.sv - shared state type and op encoding for the extended-ALU dispatcher
package exalu_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} exalu_state_t;

  localparam int OP_NONE    = 0;
  localparam int OP_AES_ENC = 1;
  localparam int OP_AES_DEC = 2;

  // Op k drives unit k-1; callers gate the result with their own legality check.
  function automatic int op2unit(input int op);
    return op - 1;
  endfunction

endpackage

// File: rtl/exalu_timeout.sv
// rtl/exalu_timeout.sv - wait-cycle counter bounding how long a unit may stay busy
module exalu_timeout #(
  parameter int TIMEOUT = 64,
  localparam int CNT_W = $clog2(TIMEOUT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  assign expired = (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/exalu_dispatch.sv
// rtl/exalu_dispatch.sv - EX-stage sequencer issuing one op at a time to iterative units
module exalu_dispatch
  import exalu_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int UNIT_W    = 128,
  parameter int NUM_UNITS = 2,
  parameter int OP_W      = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        valid,
  input  logic [OP_W-1:0]             alucontrol,
  input  logic [DATA_W-1:0]           D1,
  input  logic [DATA_W-1:0]           D2,
  output logic [DATA_W-1:0]           aluout,
  output logic                        busy,
  output logic                        error,
  output logic [NUM_UNITS-1:0]        unit_start,
  output logic [UNIT_W-1:0]           unit_a,
  output logic [UNIT_W-1:0]           unit_b,
  input  logic [NUM_UNITS-1:0]        unit_busy,
  input  logic [NUM_UNITS*UNIT_W-1:0] unit_result
);

  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  exalu_state_t     state, nextState;
  logic [SEL_W-1:0] sel, reqSel;
  logic             opLegal, opNone, accept, illegal, unitDone, timeoutHit;
  logic [CNT_W-1:0] waitCount;
  logic             expired;
  logic [UNIT_W-1:0] selResult;

  assign opNone  = (alucontrol == OP_W'(OP_NONE));
  assign opLegal = !opNone && (int'(alucontrol) <= NUM_UNITS);
  assign reqSel  = SEL_W'(op2unit(int'(alucontrol)));

  assign accept  = (state == S_IDLE) && valid && opLegal && !unit_busy[reqSel];
  assign illegal = (state == S_IDLE) && valid && !opLegal && !opNone;

  // A zero count marks the arming cycle, where the unit has not yet raised busy.
  assign unitDone   = (state == S_WAIT) && (waitCount != '0) && !unit_busy[sel];
  assign timeoutHit = (state == S_WAIT) && expired && !unitDone;
  assign selResult  = unit_result[sel*UNIT_W +: UNIT_W];

  exalu_timeout #(.TIMEOUT(TIMEOUT)) uTimeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == S_ISSUE),
    .enable  (state == S_WAIT),
    .count   (waitCount),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (accept) nextState = S_ISSUE;
      S_ISSUE: nextState = S_WAIT;
      S_WAIT:  if (unitDone || timeoutHit) nextState = S_DONE;
      S_DONE:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      S_IDLE:          busy = valid && opLegal;
      S_ISSUE, S_WAIT: busy = 1'b1;
      default:         busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel        <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      unit_start <= '0;
      error      <= 1'b0;
      aluout     <= '0;
    end else begin
      unit_start <= '0;
      error      <= 1'b0;
      if (accept) begin
        sel        <= reqSel;
        unit_a     <= D1[UNIT_W-1:0];
        unit_b     <= D2[UNIT_W-1:0];
        unit_start <= NUM_UNITS'(1) << reqSel;
      end
      if (illegal || timeoutHit) begin
        aluout <= '0;
        error  <= 1'b1;
      end
      if (unitDone) aluout <= DATA_W'(selResult);
    end
  end

  // Operand bits above the unit width are deliberately dropped.
  generate
    if (DATA_W > UNIT_W) begin : gUpper
      logic unusedUpper;
      assign unusedUpper = ^{D1[DATA_W-1:UNIT_W], D2[DATA_W-1:UNIT_W]};
    end
  endgenerate

endmodule

// File: tb/tb_exalu_dispatch.sv
// tb/tb_exalu_dispatch.sv - directed bench for exalu_dispatch with fixed-latency unit models
module tb_exalu_dispatch;

  localparam int L = 11;
  localparam int TIMEOUT = 64;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] HI  = 128'hdeadbeefcafef00d0123456789abcdef;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         valid = 1'b0;
  logic [2:0]   alucontrol = 3'd0;
  logic [255:0] D1 = '0, D2 = '0;
  logic [255:0] aluout;
  logic         busy, error;
  logic [1:0]   unit_start, unit_busy;
  logic [127:0] unit_a, unit_b;
  logic [255:0] unit_result;

  logic [1:0]   modelBusy;
  int           modelCnt [2];
  logic [127:0] modelRes [2];
  logic         hang = 1'b0;
  logic         forceBusy0 = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  exalu_dispatch dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid       (valid),
    .alucontrol  (alucontrol),
    .D1          (D1),
    .D2          (D2),
    .aluout      (aluout),
    .busy        (busy),
    .error       (error),
    .unit_start  (unit_start),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_busy   (unit_busy),
    .unit_result (unit_result)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] unitFn(input int k, input logic [127:0] a, input logic [127:0] b);
    if (k == 0) return (a == PT && b == KEY) ? CT : ~a;
    return (a == CT && b == KEY) ? PT : ~a;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      modelBusy <= '0;
      for (int k = 0; k < 2; k++) begin
        modelCnt[k] <= 0;
        modelRes[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (unit_start[k]) begin
          modelCnt[k]  <= L;
          modelBusy[k] <= 1'b1;
          modelRes[k]  <= unitFn(k, unit_a, unit_b);
        end else if (modelCnt[k] > 1 && !hang) begin
          modelCnt[k] <= modelCnt[k] - 1;
        end else if (modelCnt[k] == 1 && !hang) begin
          modelCnt[k]  <= 0;
          modelBusy[k] <= 1'b0;
        end
      end
    end
  end

  assign unit_busy   = modelBusy | {1'b0, forceBusy0};
  assign unit_result = {modelRes[1], modelRes[0]};

  task automatic runOp(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b,
                       output int busyCycles, output int starts, output logic [1:0] startSeen,
                       output bit timedOut);
    busyCycles = 0; starts = 0; startSeen = '0; timedOut = 1'b1;
    @(negedge clock);
    valid = 1'b1; alucontrol = op; D1 = a; D2 = b;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (unit_start != 2'b00) begin starts++; startSeen |= unit_start; end
      if (!busy) begin timedOut = 1'b0; break; end
      busyCycles++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    @(negedge clock); #1;
    testsRun++; if (aluout !== '0) begin testsFailed++; $display("FAIL reset_aluout: got %h want 0", aluout); end
    testsRun++; if (busy !== 1'b0 || error !== 1'b0 || unit_start !== 2'b00) begin
      testsFailed++; $display("FAIL reset_ctrl: got busy=%b error=%b start=%b want 0/0/00", busy, error, unit_start); end
    testsRun++; if (unit_a !== '0 || unit_b !== '0) begin
      testsFailed++; $display("FAIL reset_operands: got a=%h b=%h want 0", unit_a, unit_b); end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_encrypt;
    int bc, st; logic [1:0] seen; bit to;
    runOp(3'd1, {HI, PT}, {HI, KEY}, bc, st, seen, to);
    testsRun++; if (to) begin testsFailed++; $display("FAIL enc_done: got no DONE want DONE within 200 cycles"); end
    testsRun++; if (bc !== L + 3) begin testsFailed++; $display("FAIL enc_busy_cycles: got %0d want %0d", bc, L + 3); end
    testsRun++; if (st !== 1 || seen !== 2'b01) begin testsFailed++; $display("FAIL enc_start: got %0d pulses mask %b want 1 pulse 01", st, seen); end
    testsRun++; if (aluout !== {128'h0, CT}) begin testsFailed++; $display("FAIL enc_result: got %h want %h", aluout, {128'h0, CT}); end
    testsRun++; if (error !== 1'b0) begin testsFailed++; $display("FAIL enc_error: got %b want 0", error); end
    valid = 1'b0; alucontrol = 3'd0;
    @(negedge clock); #1;
    testsRun++; if (busy !== 1'b0 || aluout !== {128'h0, CT}) begin
      testsFailed++; $display("FAIL enc_hold: got busy=%b aluout=%h want 0 and held result", busy, aluout); end
  endtask

  task automatic test_illegal;
    @(negedge clock);
    valid = 1'b1; alucontrol = 3'd5; D1 = {HI, PT}; D2 = {HI, KEY};
    #1;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("FAIL ill_busy: got %b want 0", busy); end
    @(negedge clock);
    valid = 1'b0; alucontrol = 3'd0;
    #1;
    testsRun++; if (error !== 1'b1) begin testsFailed++; $display("FAIL ill_error: got %b want 1", error); end
    testsRun++; if (aluout !== '0) begin testsFailed++; $display("FAIL ill_aluout: got %h want 0", aluout); end
    testsRun++; if (unit_start !== 2'b00) begin testsFailed++; $display("FAIL ill_start: got %b want 00", unit_start); end
    @(negedge clock); #1;
    testsRun++; if (error !== 1'b0) begin testsFailed++; $display("FAIL ill_pulse_width: got %b want 0", error); end
  endtask

  task automatic test_decrypt;
    int bc, st; logic [1:0] seen; bit to;
    runOp(3'd2, {HI, CT}, {HI, KEY}, bc, st, seen, to);
    testsRun++; if (to || bc !== L + 3) begin testsFailed++; $display("FAIL dec_busy_cycles: got %0d timedout=%b want %0d", bc, to, L + 3); end
    testsRun++; if (st !== 1 || seen !== 2'b10) begin testsFailed++; $display("FAIL dec_start: got %0d pulses mask %b want 1 pulse 10", st, seen); end
    testsRun++; if (aluout !== {128'h0, PT}) begin testsFailed++; $display("FAIL dec_result: got %h want %h", aluout, {128'h0, PT}); end
    testsRun++; if (error !== 1'b0) begin testsFailed++; $display("FAIL dec_error: got %b want 0", error); end
    valid = 1'b0; alucontrol = 3'd0;
    @(negedge clock);
  endtask

  task automatic test_timeout;
    int bc, st; logic [1:0] seen; bit to;
    hang = 1'b1;
    runOp(3'd1, {HI, PT}, {HI, KEY}, bc, st, seen, to);
    testsRun++; if (to || bc !== TIMEOUT + 2) begin testsFailed++; $display("FAIL to_busy_cycles: got %0d timedout=%b want %0d", bc, to, TIMEOUT + 2); end
    testsRun++; if (error !== 1'b1) begin testsFailed++; $display("FAIL to_error: got %b want 1", error); end
    testsRun++; if (aluout !== '0) begin testsFailed++; $display("FAIL to_aluout: got %h want 0", aluout); end
    valid = 1'b0; alucontrol = 3'd0;
    @(negedge clock); #1;
    testsRun++; if (error !== 1'b0 || busy !== 1'b0) begin
      testsFailed++; $display("FAIL to_after: got error=%b busy=%b want 0/0", error, busy); end
    hang = 1'b0;
  endtask

  task automatic test_busy_unit;
    bit done = 1'b0;
    for (int i = 0; i < 40 && modelBusy != 2'b00; i++) @(negedge clock);
    @(negedge clock);
    forceBusy0 = 1'b1;
    valid = 1'b1; alucontrol = 3'd1; D1 = {HI, PT}; D2 = {HI, KEY};
    for (int i = 0; i < 3; i++) begin
      #1;
      testsRun++; if (busy !== 1'b1 || unit_start !== 2'b00) begin
        testsFailed++; $display("FAIL bu_stall%0d: got busy=%b start=%b want 1/00", i, busy, unit_start); end
      @(negedge clock);
    end
    forceBusy0 = 1'b0;
    #1;
    testsRun++; if (unit_start !== 2'b00) begin testsFailed++; $display("FAIL bu_release: got start=%b want 00", unit_start); end
    @(negedge clock); #1;
    testsRun++; if (unit_start !== 2'b01) begin testsFailed++; $display("FAIL bu_issue: got start=%b want 01", unit_start); end
    D1 = {HI, ~PT};
    @(negedge clock);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!busy) begin done = 1'b1; break; end
      @(negedge clock);
    end
    testsRun++; if (!done || aluout !== {128'h0, CT}) begin
      testsFailed++; $display("FAIL bu_result: got %h done=%b want %h", aluout, done, {128'h0, CT}); end
    valid = 1'b0; alucontrol = 3'd0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int bc, st; logic [1:0] seen; bit to;
    runOp(3'd1, {HI, PT}, {HI, KEY}, bc, st, seen, to);
    testsRun++; if (to || aluout !== {128'h0, CT}) begin testsFailed++; $display("FAIL b2b_first: got %h want %h", aluout, {128'h0, CT}); end
    @(negedge clock); #1;
    testsRun++; if (busy !== 1'b1 || unit_start !== 2'b00) begin
      testsFailed++; $display("FAIL b2b_idle: got busy=%b start=%b want 1/00", busy, unit_start); end
    @(negedge clock); #1;
    testsRun++; if (unit_start !== 2'b01) begin testsFailed++; $display("FAIL b2b_reissue: got start=%b want 01", unit_start); end
  endtask

  task automatic test_reset_mid_wait;
    for (int i = 0; i < 4; i++) @(negedge clock);
    reset_n = 1'b0; valid = 1'b0; alucontrol = 3'd0;
    #1;
    testsRun++; if (aluout !== '0 || busy !== 1'b0 || unit_start !== 2'b00) begin
      testsFailed++; $display("FAIL rst_wait: got aluout=%h busy=%b start=%b want 0/0/00", aluout, busy, unit_start); end
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      testsRun++; if (unit_start !== 2'b00 || busy !== 1'b0) begin
        testsFailed++; $display("FAIL rst_release%0d: got start=%b busy=%b want 00/0", i, unit_start, busy); end
    end
  endtask

  initial begin
    test_reset;
    test_encrypt;
    test_illegal;
    test_decrypt;
    test_timeout;
    test_busy_unit;
    test_back_to_back;
    test_reset_mid_wait;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
